serial_mult_collect: RTL

- Downstream consumer of serial_multiplier.
- Watches the multiplier step counter `i`, detects completion of each product, and captures {a, b, s} into a small FIFO.
- Presents captured results on a valid/ready stream to the next stage.
- Maintains a running sum of accepted products and a product count for system-level checks.

---
 rtl/serial_mult_collect.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_mult_collect.sv
// rtl/serial_mult_collect.sv - captures finished serial_multiplier products into a FWFT FIFO stream
//
// Optional self-check of each product is enabled by defining SERIAL_MULT_CHECK_EN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a_in, b_in, s_in    multiplier operands and product as seen by the multiplier
//   i_in                multiplier step counter; product is final when it reaches DONE_STEP
//   clr                 synchronous clear of acc, acc_ovf, prod_cnt, drop_cnt, chk_err
//   out_valid/out_ready head-of-FIFO handshake; out_a/out_b/out_prod carry the head entry
//   fifo_full           FIFO holds DEPTH entries
//   acc, acc_ovf        running sum of accepted products, sticky carry-out flag
//   prod_cnt            accepted products (wrapping), drop_cnt dropped completions (saturating)
//   chk_err             sticky product mismatch flag (0 when the self-check is not built)
module serial_mult_collect #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int STEP_W    = 4,
    parameter int DONE_STEP = 4,
    parameter int ACC_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [2*WIDTH-1:0]   s_in,
    input  logic [STEP_W-1:0]    i_in,
    input  logic                 clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 fifo_full,
    output logic [ACC_W-1:0]     acc,
    output logic                 acc_ovf,
    output logic [7:0]           prod_cnt,
    output logic [7:0]           drop_cnt,
    output logic                 chk_err
);

    localparam int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [STEP_W-1:0] DONE_V   = STEP_W'(DONE_STEP);
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);

    logic [STEP_W-1:0]  i_q;
    logic [WIDTH-1:0]   mem_a [DEPTH];
    logic [WIDTH-1:0]   mem_b [DEPTH];
    logic [2*WIDTH-1:0] mem_p [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    logic               done;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ACC_W:0]     acc_sum;

    // Rising edge into DONE_STEP: one pulse per product even if i_in parks there.
    // i_q resets to DONE_STEP so a counter already at DONE_STEP at release is ignored.
    assign done      = (i_in == DONE_V) && (i_q != DONE_V);
    assign out_valid = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // A full FIFO can still take the new entry when the head leaves this cycle.
    assign push      = done && (!fifo_full || pop);
    assign drop      = done && fifo_full && !pop;
    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(s_in);

    assign out_a    = mem_a[rd_ptr];
    assign out_b    = mem_b[rd_ptr];
    assign out_prod = mem_p[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q    <= DONE_V;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_a[k] <= '0;
                mem_b[k] <= '0;
                mem_p[k] <= '0;
            end
        end else begin
            i_q <= i_in;
            if (push) begin
                mem_a[wr_ptr] <= a_in;
                mem_b[wr_ptr] <= b_in;
                mem_p[wr_ptr] <= s_in;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Statistics; clr takes priority over a same-cycle accepted push or drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            acc_ovf  <= 1'b0;
            prod_cnt <= '0;
            drop_cnt <= '0;
        end else if (clr) begin
            acc      <= '0;
            acc_ovf  <= 1'b0;
            prod_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                acc      <= acc_sum[ACC_W-1:0];
                acc_ovf  <= acc_ovf | acc_sum[ACC_W];
                prod_cnt <= prod_cnt + 8'd1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef SERIAL_MULT_CHECK_EN
    logic [2*WIDTH-1:0] ref_prod;
    logic               chk_bad;

    // Checked on every completion, whether the entry is kept or dropped.
    assign ref_prod = (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);
    assign chk_bad  = done && (ref_prod != s_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (clr) begin
            chk_err <= 1'b0;
        end else if (chk_bad) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
